// File: rtl/rob_commit_if.sv
// Reorder-buffer port bundle: dispatch, CDB writeback, regfile nick/commit
// ports and the flush/redirect pair. The ROB uses the master modport; the
// pipeline (or a bench) uses the slave modport.
//
// Handshake: dispatch is a valid/ready pair. iDP_en is valid and ~oDP_full is
// ready; an instruction transfers on a rising clk edge where rdy & iDP_en &
// ~oDP_full. CDB results are valid-only (iCDB_en) and are never back-pressured.
// oRF_en and oclr are single-cycle valid strobes with no ready.
interface rob_commit_if #(
    parameter int NICK_W = 5,
    parameter int IDX_W  = 4
);
    logic              rdy;
    logic              iDP_en;
    logic [4:0]        iDP_rd_regnm;
    logic              iDP_has_rd;
    logic              iDP_is_br;
    logic              iDP_pd;
    logic [31:0]       iDP_pc;
    logic [NICK_W-1:0] oDP_nick;
    logic              oDP_full;
    logic              oRF_nick_en;
    logic [4:0]        oRF_nick_regnm;
    logic [NICK_W-1:0] oRF_nick;
    logic              iCDB_en;
    logic [NICK_W-1:0] iCDB_nick;
    logic [31:0]       iCDB_dt;
    logic              iCDB_jump;
    logic [31:0]       iCDB_tgt;
    logic              oRF_en;
    logic [4:0]        oRF_rd_regnm;
    logic [31:0]       oRF_rd_dt;
    logic [NICK_W-1:0] oRF_rd_nick;
    logic              oclr;
    logic [31:0]       oIF_pc;
    logic [IDX_W:0]    dbg_count;

    modport master (
        input  rdy, iDP_en, iDP_rd_regnm, iDP_has_rd, iDP_is_br, iDP_pd, iDP_pc,
        input  iCDB_en, iCDB_nick, iCDB_dt, iCDB_jump, iCDB_tgt,
        output oDP_nick, oDP_full, oRF_nick_en, oRF_nick_regnm, oRF_nick,
        output oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick, oclr, oIF_pc,
        output dbg_count
    );

    modport slave (
        output rdy, iDP_en, iDP_rd_regnm, iDP_has_rd, iDP_is_br, iDP_pd, iDP_pc,
        output iCDB_en, iCDB_nick, iCDB_dt, iCDB_jump, iCDB_tgt,
        input  oDP_nick, oDP_full, oRF_nick_en, oRF_nick_regnm, oRF_nick,
        input  oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick, oclr, oIF_pc,
        input  dbg_count
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: allocates nicks (entry index + 1) at dispatch, captures CDB
// results, retires in program order and flushes on a retiring branch
// mispredict. Optional commit/flush trace: define ROB_COMMIT_TRACE_EN.
module rob_commit #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4,
    parameter int NICK_W   = 5
) (
    input logic          clk,
    input logic          rst,
    rob_commit_if.master bus
);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0] has_rd_q, has_rd_d, is_br_q, is_br_d;
    logic [ROB_SIZE-1:0] pd_q, pd_d, jump_q, jump_d;
    logic [4:0]          regnm_q [ROB_SIZE];
    logic [4:0]          regnm_d [ROB_SIZE];
    logic [31:0]         dt_q    [ROB_SIZE];
    logic [31:0]         dt_d    [ROB_SIZE];
    logic [31:0]         pc_q    [ROB_SIZE];
    logic [31:0]         pc_d    [ROB_SIZE];
    logic [31:0]         tgt_q   [ROB_SIZE];
    logic [31:0]         tgt_d   [ROB_SIZE];

    logic                rf_en_q, rf_en_d, clr_q, clr_d;
    logic [4:0]          rf_regnm_q, rf_regnm_d;
    logic [31:0]         rf_dt_q, rf_dt_d, if_pc_q, if_pc_d;
    logic [NICK_W-1:0]   rf_nick_q, rf_nick_d;

    logic                full, accept, commit, mispredict, wb_hit;
    logic [NICK_W-1:0]   wb_m1, tail_nick, head_nick;
    logic [IDX_W-1:0]    wb_idx;
    logic [4:0]          commit_rd;
    logic [31:0]         redirect_pc;

    // Full ignores a same-cycle commit on purpose: keeps the stall path short.
    assign full        = (count_q == CNT_W'(ROB_SIZE));
    assign accept      = bus.rdy & bus.iDP_en & ~full;
    assign commit      = bus.rdy & busy_q[head_q] & ready_q[head_q];
    assign mispredict  = commit & is_br_q[head_q] & (jump_q[head_q] != pd_q[head_q]);
    assign wb_m1       = bus.iCDB_nick - NICK_W'(1);
    assign wb_idx      = wb_m1[IDX_W-1:0];
    assign wb_hit      = bus.rdy & bus.iCDB_en & (bus.iCDB_nick != '0)
                       & (bus.iCDB_nick <= NICK_W'(ROB_SIZE)) & busy_q[wb_idx];
    assign tail_nick   = NICK_W'(tail_q) + NICK_W'(1);
    assign head_nick   = NICK_W'(head_q) + NICK_W'(1);
    // Branches and stores carry no rd, so they retire as a write to x0.
    assign commit_rd   = has_rd_q[head_q] ? regnm_q[head_q] : 5'd0;
    assign redirect_pc = jump_q[head_q] ? tgt_q[head_q] : pc_q[head_q] + 32'd4;

    assign bus.oDP_nick       = tail_nick;
    assign bus.oDP_full       = full;
    assign bus.oRF_nick_en    = accept & bus.iDP_has_rd & (bus.iDP_rd_regnm != 5'd0);
    assign bus.oRF_nick_regnm = bus.iDP_rd_regnm;
    assign bus.oRF_nick       = tail_nick;
    assign bus.oRF_en         = rf_en_q;
    assign bus.oRF_rd_regnm   = rf_regnm_q;
    assign bus.oRF_rd_dt      = rf_dt_q;
    assign bus.oRF_rd_nick    = rf_nick_q;
    assign bus.oclr           = clr_q;
    assign bus.oIF_pc         = if_pc_q;
    assign bus.dbg_count      = count_q;

    // Next state: commit at head, CDB capture, dispatch at tail, then flush override.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        has_rd_d   = has_rd_q;
        is_br_d    = is_br_q;
        pd_d       = pd_q;
        jump_d     = jump_q;
        regnm_d    = regnm_q;
        dt_d       = dt_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        rf_en_d    = rf_en_q;
        rf_regnm_d = rf_regnm_q;
        rf_dt_d    = rf_dt_q;
        rf_nick_d  = rf_nick_q;
        clr_d      = 1'b0;
        if_pc_d    = if_pc_q;
        if (bus.rdy) begin
            rf_en_d = commit;
            if (commit) begin
                rf_regnm_d      = commit_rd;
                rf_dt_d         = (commit_rd == 5'd0) ? 32'd0 : dt_q[head_q];
                rf_nick_d       = head_nick;
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + IDX_W'(1);
            end
            if (wb_hit) begin
                ready_d[wb_idx] = 1'b1;
                dt_d[wb_idx]    = bus.iCDB_dt;
                jump_d[wb_idx]  = bus.iCDB_jump;
                tgt_d[wb_idx]   = bus.iCDB_tgt;
            end
            if (accept) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = 1'b0;
                has_rd_d[tail_q] = bus.iDP_has_rd;
                is_br_d[tail_q]  = bus.iDP_is_br;
                pd_d[tail_q]     = bus.iDP_pd;
                regnm_d[tail_q]  = bus.iDP_rd_regnm;
                pc_d[tail_q]     = bus.iDP_pc;
                tail_d           = tail_q + IDX_W'(1);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(commit);
            if (mispredict) begin
                clr_d   = 1'b1;
                if_pc_d = redirect_pc;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
                ready_d = '0;
            end
        end
    end

    // Control state and registered outputs; reset beats any pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ready_q    <= '0;
            rf_en_q    <= 1'b0;
            rf_regnm_q <= '0;
            rf_dt_q    <= '0;
            rf_nick_q  <= '0;
            clr_q      <= 1'b0;
            if_pc_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            rf_en_q    <= rf_en_d;
            rf_regnm_q <= rf_regnm_d;
            rf_dt_q    <= rf_dt_d;
            rf_nick_q  <= rf_nick_d;
            clr_q      <= clr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    // Entry payload; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        has_rd_q <= has_rd_d;
        is_br_q  <= is_br_d;
        pd_q     <= pd_d;
        jump_q   <= jump_d;
        regnm_q  <= regnm_d;
        dt_q     <= dt_d;
        pc_q     <= pc_d;
        tgt_q    <= tgt_d;
    end

`ifdef ROB_COMMIT_TRACE_EN
    // Commit and flush trace for simulation logs.
    always_ff @(posedge clk) begin
        if (!rst && commit)
            $display("COMMIT pc=%h rd=%0d dt=%h nick=%0d", pc_q[head_q], commit_rd,
                     (commit_rd == 5'd0) ? 32'd0 : dt_q[head_q], head_nick);
        if (!rst && mispredict)
            $display("FLUSH tgt=%h", redirect_pc);
    end
`endif
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic against a
// queue-based model of the in-order buffer.
module tb_rob_commit;
    localparam int W = 75;

    typedef struct {
        int         nick;
        bit         has_rd, is_br, pd, ready, jump;
        bit [4:0]   regnm;
        bit [31:0]  pc, dt, tgt;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_commit_if #(.NICK_W(5), .IDX_W(4)) tif();
    rob_commit #(.ROB_SIZE(16), .IDX_W(4), .NICK_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(tif.master)
    );

    ent_t           rob_m[$];
    int             next_nick = 1;
    logic [31:0]    last_pc = '0;
    logic [W-1:0]   exp_q[$];
    int             n_chk = 0;
    int             n_pass = 0;
    logic           rdy_seen = 1'b0;
    logic           rst_seen = 1'b1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic clr_in();
        tif.rdy = 1'b1; tif.iDP_en = 1'b0; tif.iCDB_en = 1'b0;
        tif.iDP_rd_regnm = '0; tif.iDP_has_rd = 1'b0; tif.iDP_is_br = 1'b0;
        tif.iDP_pd = 1'b0; tif.iDP_pc = '0; tif.iCDB_nick = '0;
        tif.iCDB_dt = '0; tif.iCDB_jump = 1'b0; tif.iCDB_tgt = '0;
    endtask

    task automatic dp(input bit [4:0] rd, input bit has_rd, input bit is_br, input bit pd,
                      input bit [31:0] pc);
        tif.iDP_en = 1'b1; tif.iDP_rd_regnm = rd; tif.iDP_has_rd = has_rd;
        tif.iDP_is_br = is_br; tif.iDP_pd = pd; tif.iDP_pc = pc;
    endtask

    task automatic cdb(input int nick, input bit [31:0] dt, input bit jump, input bit [31:0] tgt);
        tif.iCDB_en = 1'b1; tif.iCDB_nick = 5'(nick); tif.iCDB_dt = dt;
        tif.iCDB_jump = jump; tif.iCDB_tgt = tgt;
    endtask

    // One clock: check combinational outputs, advance the model, cross the edge.
    task automatic tick();
        bit full, acc, mis;
        ent_t e;
        bit [4:0] rd;
        bit [31:0] dt;
        #1;
        full = (rob_m.size() == 16);
        acc  = tif.rdy && tif.iDP_en && !full;
        if (!rst) begin
            chk("dp_full", tif.oDP_full, full);
            chk("dp_nick", tif.oDP_nick, next_nick);
            chk("nick_en", tif.oRF_nick_en, acc && tif.iDP_has_rd && tif.iDP_rd_regnm != 0);
            chk("count", tif.dbg_count, rob_m.size());
            if (acc) chk("nick_wr", {tif.oRF_nick_regnm, tif.oRF_nick},
                         {tif.iDP_rd_regnm, 5'(next_nick)});
        end
        if (rst) begin
            rob_m.delete(); exp_q.delete(); next_nick = 1; last_pc = '0;
        end else if (tif.rdy) begin
            mis = 1'b0;
            if (rob_m.size() > 0 && rob_m[0].ready) begin
                e   = rob_m.pop_front();
                rd  = e.has_rd ? e.regnm : 5'd0;
                dt  = (rd == 0) ? 32'd0 : e.dt;
                mis = e.is_br && (e.jump != e.pd);
                if (mis) last_pc = e.jump ? e.tgt : e.pc + 32'd4;
                exp_q.push_back({rd, dt, 5'(e.nick), mis, last_pc});
            end
            if (mis) begin
                rob_m.delete(); next_nick = 1;
            end else begin
                if (tif.iCDB_en)
                    foreach (rob_m[i])
                        if (rob_m[i].nick == int'(tif.iCDB_nick)) begin
                            rob_m[i].ready = 1'b1; rob_m[i].dt = tif.iCDB_dt;
                            rob_m[i].jump = tif.iCDB_jump; rob_m[i].tgt = tif.iCDB_tgt;
                        end
                if (acc) begin
                    e = '{nick: next_nick, has_rd: tif.iDP_has_rd, is_br: tif.iDP_is_br,
                          pd: tif.iDP_pd, ready: 1'b0, jump: 1'b0, regnm: tif.iDP_rd_regnm,
                          pc: tif.iDP_pc, dt: 32'd0, tgt: 32'd0};
                    rob_m.push_back(e);
                    next_nick = next_nick % 16 + 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        clr_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out", {tif.oRF_en, tif.oRF_rd_regnm, tif.oRF_rd_dt, tif.oRF_rd_nick,
                        tif.oclr, tif.oIF_pc}, '0);
        chk("rst_nick", {tif.oDP_nick, tif.dbg_count, tif.oDP_full}, {5'd1, 5'd0, 1'b0});
    endtask

    always @(posedge clk) begin
        rdy_seen <= tif.rdy;
        rst_seen <= rst;
    end

    // Monitor: every modelled commit must appear one edge later, in order.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_seen) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_en", tif.oRF_en, 1'b1);
                chk("commit", {tif.oRF_rd_regnm, tif.oRF_rd_dt, tif.oRF_rd_nick,
                               tif.oclr, tif.oIF_pc}, e);
            end else begin
                chk("oclr_idle", tif.oclr, 1'b0);
                if (rdy_seen) chk("rf_en_idle", tif.oRF_en, 1'b0);
            end
        end
    end

    initial begin
        int cand[$];
        clr_in();
        @(negedge clk);

        // First dispatch, writeback, commit two cycles after the CDB
        reset_dut();
        dp(5, 1, 0, 0, 32'h100);
        #1 chk("t1_nick", {tif.oDP_nick, tif.oRF_nick_en, tif.oRF_nick_regnm, tif.oRF_nick},
               {5'd1, 1'b1, 5'd5, 5'd1});
        tick();
        clr_in(); cdb(1, 32'h2A, 0, 0); tick();
        clr_in(); tick();
        chk("t1_commit", {tif.oRF_en, tif.oRF_rd_regnm, tif.oRF_rd_dt, tif.oRF_rd_nick},
            {1'b1, 5'd5, 32'h2A, 5'd1});
        tick();

        // Fill, stall, free one entry, wrap
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            dp(5'(i + 1), 1, 0, 0, 32'(i * 4)); tick();
        end
        dp(9, 1, 0, 0, 32'h40);
        #1 chk("t2_full", {tif.oDP_full, tif.oRF_nick_en}, {1'b1, 1'b0});
        tick();
        clr_in(); cdb(1, 32'h11, 0, 0); tick();
        clr_in(); tick();
        chk("t2_free", tif.oDP_full, 1'b0);
        dp(9, 1, 0, 0, 32'h44);
        #1 chk("t2_wrap", tif.oDP_nick, 5'd1);
        tick();
        clr_in(); tick();

        // Out-of-order results, in-order retirement
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            dp(5'(10 + i), 1, 0, 0, 32'(i * 4)); tick();
        end
        for (int i = 3; i >= 1; i--) begin
            clr_in(); cdb(i, 32'(i * 100), 0, 0); tick();
        end
        clr_in();
        repeat (4) tick();

        // Taken mispredict with three younger entries
        reset_dut();
        dp(0, 0, 1, 0, 32'h200); tick();
        for (int i = 0; i < 3; i++) begin
            dp(5'(i + 1), 1, 0, 0, 32'h204 + 32'(i * 4)); tick();
        end
        clr_in(); cdb(1, 0, 1, 32'h300); tick();
        clr_in(); tick();
        chk("t4_flush", {tif.oclr, tif.oIF_pc, tif.oRF_rd_regnm}, {1'b1, 32'h300, 5'd0});
        tick();
        chk("t4_after", {tif.oclr, tif.dbg_count, tif.oDP_nick}, {1'b0, 5'd0, 5'd1});

        // Not-taken mispredict, then a correct prediction
        reset_dut();
        dp(0, 0, 1, 1, 32'h400); tick();
        clr_in(); cdb(1, 0, 0, 0); tick();
        clr_in(); tick();
        chk("t5_nt", {tif.oclr, tif.oIF_pc}, {1'b1, 32'h404});
        dp(0, 0, 1, 1, 32'h500); tick();
        clr_in(); cdb(1, 0, 1, 32'h999); tick();
        clr_in(); tick();
        chk("t5_ok", {tif.oclr, tif.oRF_en, tif.oIF_pc}, {1'b0, 1'b1, 32'h404});

        // rdy low stalls retirement; reset beats a pending mispredict
        reset_dut();
        dp(7, 1, 0, 0, 32'h10); tick();
        clr_in(); cdb(1, 32'h55, 0, 0); tick();
        clr_in(); tif.rdy = 1'b0;
        repeat (3) tick();
        chk("t6_stall", tif.oRF_en, 1'b0);
        tif.rdy = 1'b1; tick();
        chk("t6_go", {tif.oRF_en, tif.oRF_rd_nick, tif.oRF_rd_dt}, {1'b1, 5'd1, 32'h55});
        dp(0, 0, 1, 0, 32'h600); tick();
        dp(3, 1, 0, 0, 32'h604); tick();
        clr_in(); cdb(2, 0, 1, 32'h700); tick();
        clr_in(); rst = 1'b1; tick();
        rst = 1'b0;
        chk("t6_rst", {tif.oRF_en, tif.oRF_rd_regnm, tif.oRF_rd_dt, tif.oRF_rd_nick,
                       tif.oclr, tif.oIF_pc}, '0);
        chk("t6_nick", tif.oDP_nick, 5'd1);

        // Random traffic
        reset_dut();
        repeat (800) begin
            clr_in();
            tif.rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6) begin
                if ($urandom_range(0, 4) == 0)
                    dp(5'($urandom_range(0, 31)), 0, 1, 1'($urandom_range(0, 1)),
                       $urandom() & 32'hFFFF_FFFC);
                else
                    dp(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0,
                       $urandom() & 32'hFFFF_FFFC);
            end
            cand.delete();
            foreach (rob_m[i]) if (!rob_m[i].ready) cand.push_back(rob_m[i].nick);
            if (cand.size() > 0 && $urandom_range(0, 9) < 6)
                cdb(cand[$urandom_range(0, cand.size() - 1)], $urandom(),
                    1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC);
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        clr_in();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer, the producer side of the register-file rename/commit interface.
- At dispatch: allocates a rename tag ("nick") per instruction and drives the regfile nick-write port.
- Captures results from the common data bus (CDB) and retires in program order, driving the regfile commit port.
- On a retiring branch mispredict: raises the pipeline-wide clr and the redirect PC.

Parameters:
- ROB_SIZE, 16, number of entries; power of two.
- IDX_W, 4, log2(ROB_SIZE).
- NICK_W, 5, nick width; nick = entry index + 1, so nick 0 always means "not renamed".

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- iDP_en  in  1  dispatch request
- iDP_rd_regnm  in  5  destination register
- iDP_has_rd  in  1  instruction writes rd (0 for stores and branches)
- iDP_is_br  in  1  conditional branch
- iDP_pd  in  1  predicted taken
- iDP_pc  in  32  instruction PC
- oDP_nick  out  NICK_W  nick granted this cycle (tail+1)
- oDP_full  out  1  no entry free; dispatch must stall
- oRF_nick_en  out  1  regfile nick write
- oRF_nick_regnm  out  5  register being renamed
- oRF_nick  out  NICK_W  new nick
- iCDB_en  in  1  result valid
- iCDB_nick  in  NICK_W  producer nick
- iCDB_dt  in  32  result data
- iCDB_jump  in  1  branch actually taken
- iCDB_tgt  in  32  branch target when taken
- oRF_en  out  1  commit valid
- oRF_rd_regnm  out  5  committed rd
- oRF_rd_dt  out  32  committed data
- oRF_rd_nick  out  NICK_W  committed nick
- oclr  out  1  flush pulse
- oIF_pc  out  32  redirect PC, valid with oclr

Behaviour:
- State: circular buffer with head, tail (IDX_W) and count (IDX_W+1). Per entry: busy, ready, has_rd, is_br, pd, regnm, dt, pc, jump, tgt.
- Reset: head=tail=count=0; all busy and ready cleared. Registered outputs oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick, oclr, oIF_pc all reset to 0.
- oDP_full = (count == ROB_SIZE), combinational. It ignores a same-cycle commit (conservative).
- Dispatch, accepted when rdy & iDP_en & !oDP_full:
  - The entry at tail is written at the posedge and tail increments with wrap.
  - Combinational outputs: oDP_nick = tail+1; oRF_nick_en = accept & iDP_has_rd & (iDP_rd_regnm != 0); oRF_nick_regnm = iDP_rd_regnm; oRF_nick = tail+1.
  - When not accepted, oRF_nick_en = 0.
- Writeback: when iCDB_en, the entry at iCDB_nick-1 takes ready=1 and captures dt, jump, tgt. A writeback to a non-busy entry is ignored. A CDB result and a dispatch to the same entry in one cycle cannot occur.
- Commit: at most one per cycle, when rdy & busy[head] & ready[head].
  - Next cycle: oRF_en=1; oRF_rd_regnm = has_rd ? regnm : 0; oRF_rd_dt = 0 if regnm is 0, else dt; oRF_rd_nick = head+1.
  - busy[head] clears and head increments.
  - Otherwise oRF_en=0 and the other commit outputs hold their values.
  - Latency: a CDB result arriving in cycle N at the head is visible on oRF_* in cycle N+2.
- Mispredict: a committing entry with is_br & (jump != pd).
  - Next cycle: oclr=1 for one cycle, together with that entry's oRF_en=1.
  - oIF_pc = jump ? tgt : pc+4.
  - In the same edge: head=tail=count=0, all busy cleared, and the same-cycle dispatch is discarded.
  - Because the regfile writes rd on clr, branches commit with rd_regnm 0 and dt 0.
- Simultaneous dispatch and commit: count unchanged. count never underflows or overflows.
- rdy low: no dispatch, commit or writeback capture; registered outputs hold. oclr drops after its single cycle regardless of rdy.
- rst mid-operation: reset wins over all events, including a pending mispredict.

Optional Feature:
- Macro: ROB_COMMIT_TRACE_EN.
- When defined: each commit prints "COMMIT pc=%h rd=%0d dt=%h nick=%0d" via $display, and each flush prints "FLUSH tgt=%h" via $display.
- When undefined: no trace logic is compiled and port behaviour is identical.

Test Plan:
- Reset, then dispatch rd=5 at pc=0x100 -> oDP_nick=1, oRF_nick_en=1, oRF_nick_regnm=5, oRF_nick=1. After CDB nick=1 dt=0x2A, two cycles later: oRF_en=1, rd_regnm=5, rd_dt=0x2A, rd_nick=1.
- Dispatch 16 instructions with no CDB -> oDP_full=1, and a 17th iDP_en produces no nick write. CDB nick=1, then commit -> full drops; the next dispatch gets nick=1 (wrap).
- CDB results arrive for nicks 3, 2, 1 in that order -> commits emerge in order nick 1, 2, 3, one per cycle.
- Branch pc=0x200, pd=0, CDB jump=1 tgt=0x300, with 3 younger entries -> oclr=1 for one cycle, oIF_pc=0x300, oRF_rd_regnm=0; afterwards count=0 and the next nick is 1.
- Branch pd=1, jump=0, pc=0x400 -> oIF_pc=0x404. Branch with pd==jump -> no oclr.
- rdy held low for 3 cycles with a ready head entry -> no commit. With rst asserted mid-sequence -> all outputs 0 and the next nick is 1.
